alu_issue_ctrl: RTL and testbench

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_decode.sv | 20 ++
 rtl/alu_issue_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and issue-FSM state encoding for the ALU issue controller.
package alu_pkg;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpDiv  = 4'd3;
  localparam logic [3:0] OpMod  = 4'd4;
  localparam logic [3:0] OpExp  = 4'd5;
  localparam logic [3:0] OpInc  = 4'd6;
  localparam logic [3:0] OpRsvd = 4'd7;
  localparam logic [3:0] OpDec  = 4'd8;
  localparam logic [3:0] OpAnd  = 4'd9;
  localparam logic [3:0] OpOr   = 4'd10;
  localparam logic [3:0] OpNand = 4'd11;
  localparam logic [3:0] OpNor  = 4'd12;
  localparam logic [3:0] OpXor  = 4'd13;
  localparam logic [3:0] OpXnor = 4'd14;
  localparam logic [3:0] OpInv  = 4'd15;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } alu_state_e;

  function automatic logic op_unsupported(input logic [3:0] op);
    return (op == OpMod) || (op == OpExp) || (op == OpRsvd);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, error and wide-result selection.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [3:0]   op_i,
  input  logic [W-1:0] b_i,
  output logic         legal_o,
  output logic         err_o,
  output logic         uses_x_o
);

  always_comb begin
    err_o    = op_unsupported(op_i) || ((op_i == OpDiv) && (b_i == '0));
    legal_o  = !err_o;
    uses_x_o = (op_i == OpMul);
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one command, drives the external ALU for a cycle, returns the result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [3:0]     in_op,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [3:0]     alu_sel,
  input  logic [W-1:0]   alu_y,
  input  logic [2*W-1:0] alu_x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_result,
  output logic           out_err,
  output logic [3:0]     out_op,
  output logic [7:0]     op_cnt
);

  alu_state_e     state_q, state_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [3:0]     alu_sel_q, alu_sel_d;
  logic [2*W-1:0] result_q, result_d;
  logic           err_q, err_d;
  logic [3:0]     op_q, op_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [3:0]   dec_op;
  logic [W-1:0] dec_b;
  logic         dec_legal, dec_err, dec_uses_x;

  // Idle classifies the incoming command; Issue reuses the decoder for the held opcode.
  assign dec_op = (state_q == StIdle) ? in_op : alu_sel_q;
  assign dec_b  = (state_q == StIdle) ? in_b  : alu_b_q;

  alu_op_decode #(
    .W (W)
  ) u_decode (
    .op_i     (dec_op),
    .b_i      (dec_b),
    .legal_o  (dec_legal),
    .err_o    (dec_err),
    .uses_x_o (dec_uses_x)
  );

  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    err_d     = err_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (dec_legal) begin
            alu_a_d   = in_a;
            alu_b_d   = in_b;
            alu_sel_d = in_op;
            state_d   = StIssue;
          end else begin
            result_d = '0;
            err_d    = dec_err;
            op_d     = in_op;
            state_d  = StResp;
          end
        end
      end
      StIssue: begin
        result_d = dec_uses_x ? alu_x : {{W{1'b0}}, alu_y};
        err_d    = 1'b0;
        op_d     = alu_sel_q;
        state_d  = StResp;
      end
      StResp: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
      op_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
      err_q     <= err_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StResp);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign out_result = result_q;
  assign out_err    = err_q;
  assign out_op     = op_q;
  assign op_cnt     = cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the alu_* ports.
module tb_alu_issue_ctrl;

  localparam int unsigned W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [3:0]     alu_sel;
  logic [W-1:0]   alu_y;
  logic [2*W-1:0] alu_x;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_result;
  logic           out_err;
  logic [3:0]     out_op;
  logic [7:0]     op_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .W (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .alu_x      (alu_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .out_op     (out_op),
    .op_cnt     (op_cnt)
  );

  // Behavioural ALU
  always_comb begin
    alu_x = alu_a * alu_b;
    case (alu_sel)
      4'd0:    alu_y = alu_a + alu_b;
      4'd1:    alu_y = alu_a - alu_b;
      4'd3:    alu_y = (alu_b == 0) ? '0 : alu_a / alu_b;
      4'd6:    alu_y = alu_a + 4'd1;
      4'd8:    alu_y = alu_a - 4'd1;
      4'd9:    alu_y = alu_a & alu_b;
      4'd10:   alu_y = alu_a | alu_b;
      4'd11:   alu_y = ~(alu_a & alu_b);
      4'd12:   alu_y = ~(alu_a | alu_b);
      4'd13:   alu_y = alu_a ^ alu_b;
      4'd14:   alu_y = ~(alu_a ^ alu_b);
      4'd15:   alu_y = ~alu_a;
      default: alu_y = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command, then wait (bounded) for out_valid and check latency and payload.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input int exp_lat, input logic [7:0] exp_res,
                        input logic exp_err);
    int lat;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = 4'd9;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_err"}, out_err, exp_err);
    check({tag, "_op"}, out_op, op);
  endtask

  task automatic release_resp(input string tag, input logic [7:0] exp_cnt);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, out_valid, 0);
    check({tag, "_cnt"}, op_cnt, exp_cnt);
  endtask

  initial begin
    int resp;
    int last_cyc;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", {out_result, out_err, out_op}, 0);
    check("rst_alu", {alu_a, alu_b, alu_sel}, 0);
    check("rst_cnt", op_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add", 4'd0, 4'd5, 4'd3, 2, 8'h08, 1'b0);
    release_resp("add", 8'd1);
    run_op("mul", 4'd2, 4'd15, 4'd15, 2, 8'hE1, 1'b0);
    release_resp("mul", 8'd2);
    run_op("sub", 4'd1, 4'd2, 4'd5, 2, 8'h0D, 1'b0);
    release_resp("sub", 8'd3);

    run_op("div0", 4'd3, 4'd9, 4'd0, 1, 8'h00, 1'b1);
    check("div0_alu_hold", {alu_a, alu_b, alu_sel}, {4'd2, 4'd5, 4'd1});
    release_resp("div0", 8'd4);
    run_op("op7", 4'd7, 4'd1, 4'd1, 1, 8'h00, 1'b1);
    release_resp("op7", 8'd5);
    run_op("mod", 4'd4, 4'd7, 4'd2, 1, 8'h00, 1'b1);
    release_resp("mod", 8'd6);
    run_op("div", 4'd3, 4'd9, 4'd2, 2, 8'h04, 1'b0);
    release_resp("div", 8'd7);

    // out_ready in IDLE is ignored
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("idle_rdy_cnt", op_cnt, 8'd7);
    check("idle_rdy_vld", out_valid, 0);

    // Back-pressure: hold for 5 cycles while another command is offered and must be ignored
    run_op("xor", 4'd13, 4'hA, 4'h6, 2, 8'h0C, 1'b0);
    in_valid = 1'b1; in_op = 4'd0; in_a = 4'd1; in_b = 4'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("xor_hold_vld", out_valid, 1);
      check("xor_hold_res", out_result, 8'h0C);
      check("xor_hold_rdy", in_ready, 0);
    end
    in_valid = 1'b0;
    check("xor_hold_cnt", op_cnt, 8'd7);
    release_resp("xor", 8'd8);
    check("xor_alu_kept", {alu_a, alu_b, alu_sel}, {4'hA, 4'h6, 4'd13});

    // Reset during ISSUE drops the command
    @(negedge clk);
    in_op = 4'd0; in_a = 4'd1; in_b = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rsti_in_issue", in_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rsti_rdy", in_ready, 1);
    check("rsti_vld", out_valid, 0);
    check("rsti_out", {out_result, out_err, out_op}, 0);
    check("rsti_alu", {alu_a, alu_b, alu_sel}, 0);
    check("rsti_cnt", op_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rsti_no_resp", {out_valid, op_cnt}, 0);

    // 256 back-to-back INV ops: count wraps, responses spaced >= 3 cycles
    @(negedge clk);
    in_op = 4'd15; in_a = 4'h3; in_b = 4'h0; in_valid = 1'b1; out_ready = 1'b1;
    resp = 0; last_cyc = 0; cyc = 0;
    while (resp < 256 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        resp++;
        if (resp > 1) check("inv_gap", (cyc - last_cyc) >= 3, 1);
        if (resp == 1 || resp == 256) check("inv_res", out_result, 8'h0C);
        if (resp == 256) begin
          check("inv_cnt_255", op_cnt, 8'd255);
          in_valid = 1'b0;
        end
        last_cyc = cyc;
      end
    end
    check("inv_resp_count", resp, 256);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("inv_cnt_wrap", op_cnt, 8'd0);
    check("inv_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
